trace_capture: RTL and testbench

- Passive debug trace capture buffer: the consumer end of the CPU core's debug_pc / debug_instr / debug_alu outputs.
- Samples the three buses once per clock into a DEPTH-entry buffer, starting either immediately or on a PC-match trigger.
- After capture, a host drains the entries in order through a valid/ready read port.
- Sits beside the CPU top in the same clock domain; used by both the bench and the on-board debug path.

---
 rtl/trace_capture.sv | 133 +++++++++++++
 tb/tb_trace_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// Debug trace capture buffer: records {pc, instr, alu} once per clock after arm (optionally
// gated by a PC-match trigger) and lets a host drain the entries through a valid/ready port.
module trace_capture #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             stop,
    input  logic             trig_en,
    input  logic [31:0]      trig_pc,
    input  logic [31:0]      debug_pc,
    input  logic [31:0]      debug_instr,
    input  logic [31:0]      debug_alu,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [31:0]      rd_pc,
    output logic [31:0]      rd_instr,
    output logic [31:0]      rd_alu,
    output logic [1:0]       state,
    output logic [PTR_W:0]   count
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam logic [PTR_W:0] CountLast = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0] CountOne  = (PTR_W + 1)'(1);

    state_e             state_q, state_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               wr_en;

    logic [95:0]        mem [DEPTH];
    logic [95:0]        rd_entry;

    // Next-state: arm overrides everything, then stop, then write, then pop.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_en    = 1'b0;

        if (arm) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = trig_en ? StArmed : StCapture;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StArmed: begin
                    if (stop) begin
                        state_d = StDone;
                    end else if (debug_pc == trig_pc) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                        state_d  = StCapture;
                    end
                end
                StCapture: begin
                    if (stop) begin
                        state_d = StDone;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                        if (count_q == CountLast) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (count_q == '0) begin
                        state_d = StIdle;
                    end else if (rd_ready) begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        count_d  = count_q - 1'b1;
                        if (count_q == CountOne) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Trace storage carries no reset; stale contents are never visible past count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= {debug_pc, debug_instr, debug_alu};
        end
    end

    always_comb begin
        rd_valid = (state_q == StDone) && (count_q != '0);
        rd_entry = rd_valid ? mem[rd_ptr_q] : 96'd0;
    end

    assign rd_pc    = rd_entry[95:64];
    assign rd_instr = rd_entry[63:32];
    assign rd_alu   = rd_entry[31:0];
    assign state    = state_q;
    assign count    = count_q;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_trace_capture;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned PTR_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             arm, stop, trig_en, rd_ready;
    logic [31:0]      trig_pc, debug_pc, debug_instr, debug_alu;
    logic             rd_valid;
    logic [31:0]      rd_pc, rd_instr, rd_alu;
    logic [1:0]       state;
    logic [PTR_W:0]   count;

    int checks = 0;
    int failures = 0;

    trace_capture #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .stop        (stop),
        .trig_en     (trig_en),
        .trig_pc     (trig_pc),
        .debug_pc    (debug_pc),
        .debug_instr (debug_instr),
        .debug_alu   (debug_alu),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_pc       (rd_pc),
        .rd_instr    (rd_instr),
        .rd_alu      (rd_alu),
        .state       (state),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    function automatic logic [31:0] alu_of(input logic [31:0] pc);
        return pc * 32'd3;
    endfunction

    // Reference model: a plain FIFO of captured samples plus a session phase.
    logic [1:0]  m_state;
    logic [95:0] mq[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 2'd0;
            mq.delete();
        end else if (arm) begin
            mq.delete();
            m_state = trig_en ? 2'd1 : 2'd2;
        end else begin
            case (m_state)
                2'd1: begin
                    if (stop) m_state = 2'd3;
                    else if (debug_pc == trig_pc) begin
                        mq.push_back({debug_pc, debug_instr, debug_alu});
                        m_state = 2'd2;
                    end
                end
                2'd2: begin
                    if (stop) m_state = 2'd3;
                    else begin
                        mq.push_back({debug_pc, debug_instr, debug_alu});
                        if (mq.size() == DEPTH) m_state = 2'd3;
                    end
                end
                2'd3: begin
                    if (mq.size() == 0) m_state = 2'd0;
                    else if (rd_ready) begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) m_state = 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            logic        exp_valid;
            logic [95:0] exp_data;
            exp_valid = (m_state == 2'd3) && (mq.size() != 0);
            exp_data  = exp_valid ? mq[0] : 96'd0;
            check("model_state", {94'd0, state}, {94'd0, m_state});
            check("model_count", {91'd0, count}, 96'(mq.size()));
            check("model_rd_valid", {95'd0, rd_valid}, {95'd0, exp_valid});
            check("model_rd_data", {rd_pc, rd_instr, rd_alu}, exp_data);
        end
    end

    // One clock: inputs change 1 time unit after the rising edge; PC advances by 4.
    task automatic cycle();
        @(posedge clk);
        #1;
        arm         = 1'b0;
        stop        = 1'b0;
        debug_pc    = debug_pc + 32'd4;
        debug_instr = instr_of(debug_pc);
        debug_alu   = alu_of(debug_pc);
    endtask

    task automatic set_pc(input logic [31:0] pc);
        debug_pc    = pc;
        debug_instr = instr_of(pc);
        debug_alu   = alu_of(pc);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; rd_ready = 1'b0;
        trig_pc = 32'd0;
        set_pc(32'h0);
        #2;
        check("reset_state", {94'd0, state}, 96'd0);
        check("reset_count", {91'd0, count}, 96'd0);
        check("reset_rd", {rd_valid, rd_pc, rd_instr, rd_alu}, 97'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        cycle();

        // Free-running capture of DEPTH samples starting after arm.
        set_pc(32'h100); trig_en = 1'b0; arm = 1'b1;
        cycle();
        for (int i = 0; i < 16; i++) begin
            check("full_capture_state", {94'd0, state}, 96'd2);
            cycle();
        end
        check("full_done_state", {94'd0, state}, 96'd3);
        check("full_done_count", {91'd0, count}, 96'd16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("full_read_pc", {64'd0, rd_pc}, 96'(32'h104 + 4 * i));
            cycle();
        end
        check("full_drained_state", {94'd0, state}, 96'd0);
        rd_ready = 1'b0;
        cycle();

        // PC-match trigger: 0x1F8/0x1FC must be skipped.
        trig_pc = 32'h200; trig_en = 1'b1; set_pc(32'h1F4); arm = 1'b1;
        cycle();                            // ARMED, pc 0x1F8
        check("trig_armed_state", {94'd0, state}, 96'd1);
        cycle(); cycle(); cycle();          // 0x1F8, 0x1FC skipped; 0x200 written
        cycle();                            // 0x204 written
        stop = 1'b1;
        cycle();
        check("trig_count", {91'd0, count}, 96'd2);
        check("trig_entry0_pc", {64'd0, rd_pc}, 96'h200);
        check("trig_entry0_instr", {64'd0, rd_instr}, 96'h0200_FDFF);
        check("trig_entry0_alu", {64'd0, rd_alu}, 96'h600);
        rd_ready = 1'b1;
        cycle();
        check("trig_entry1_pc", {64'd0, rd_pc}, 96'h204);
        cycle();
        check("trig_drained_state", {94'd0, state}, 96'd0);
        rd_ready = 1'b0;

        // Early stop after three samples, then back-pressure on the read port.
        trig_en = 1'b0; set_pc(32'h300); arm = 1'b1;
        cycle(); cycle(); cycle(); cycle();
        stop = 1'b1;
        cycle();
        check("stop_state", {94'd0, state}, 96'd3);
        check("stop_count", {91'd0, count}, 96'd3);
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", {95'd0, rd_valid}, 96'd1);
            check("hold_pc", {64'd0, rd_pc}, 96'h304);
            cycle();
        end
        rd_ready = 1'b1;
        cycle(); cycle(); cycle();
        check("stop_drain_count", {91'd0, count}, 96'd0);
        check("stop_drain_state", {94'd0, state}, 96'd0);
        rd_ready = 1'b0;

        // Stop while armed with no match: empty DONE for one cycle.
        trig_en = 1'b1; trig_pc = 32'hDEAD_0001; arm = 1'b1;
        cycle();
        stop = 1'b1;
        cycle();
        check("armed_stop_state", {94'd0, state}, 96'd3);
        check("armed_stop_count", {91'd0, count}, 96'd0);
        check("armed_stop_valid", {95'd0, rd_valid}, 96'd0);
        cycle();
        check("armed_stop_idle", {94'd0, state}, 96'd0);

        // arm and rd_ready together in DONE with eight entries: arm wins.
        trig_en = 1'b0; set_pc(32'h400); arm = 1'b1;
        cycle();
        for (int i = 0; i < 8; i++) cycle();
        stop = 1'b1;
        cycle();
        check("pre_rearm_count", {91'd0, count}, 96'd8);
        trig_en = 1'b1; trig_pc = 32'hDEAD_0001; arm = 1'b1; rd_ready = 1'b1;
        cycle();
        check("rearm_count", {91'd0, count}, 96'd0);
        check("rearm_state", {94'd0, state}, 96'd1);
        check("rearm_valid", {95'd0, rd_valid}, 96'd0);
        rd_ready = 1'b0; stop = 1'b1;
        cycle(); cycle();

        // Asynchronous reset in the middle of a capture with five entries.
        trig_en = 1'b0; set_pc(32'h500); arm = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) cycle();
        check("pre_reset_count", {91'd0, count}, 96'd5);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_state", {94'd0, state}, 96'd0);
        check("async_reset_count", {91'd0, count}, 96'd0);
        check("async_reset_valid", {95'd0, rd_valid}, 96'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
